unstrip_lane_sequencer: RTL

//  Controls the 4-lane byte unstriping path. Accepts one 4-lane symbol group
//  per handshake and aligns the lanes on a common COM group. It then

---
 rtl/unstrip_lane_sequencer.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/unstrip_lane_sequencer.sv
// Handshaked 4-lane unstriping sequencer: aligns lanes on a COM group, then
// serialises lanes 0..3 onto one byte stream. Optional macro: SKP_DROP_EN.
package unstrip_lane_sequencer_pkg;

    localparam int unsigned LANES  = 4;
    localparam int unsigned BYTE_W = 8;

    typedef struct packed {
        logic              dk;
        logic [BYTE_W-1:0] data;
    } lane_sym_t;

    typedef lane_sym_t [LANES-1:0] lane_group_t;

    typedef enum logic [1:0] {
        ST_ALIGN = 2'd0,
        ST_RUN   = 2'd1,
        ST_ERR   = 2'd2
    } state_t;

endpackage

module unstrip_lane_sequencer
    import unstrip_lane_sequencer_pkg::*;
#(
    parameter logic [7:0]  COM_SYM   = 8'hBC,
    parameter logic [7:0]  SKP_SYM   = 8'h1C,
    parameter int unsigned MAX_RETRY = 3
) (
    input  logic       CLK,
    input  logic       RESET_L,
    input  logic       IN_VALID,
    output logic       IN_READY,
    input  logic [7:0] LANE0,
    input  logic [7:0] LANE1,
    input  logic [7:0] LANE2,
    input  logic [7:0] LANE3,
    input  logic       DK_0,
    input  logic       DK_1,
    input  logic       DK_2,
    input  logic       DK_3,
    output logic       OUT_VALID,
    input  logic       OUT_READY,
    output logic [7:0] D,
    output logic       DK,
    input  logic       RESYNC,
    output logic       ALIGNED,
    output logic       ALIGN_ERR
);

    localparam int unsigned DEPTH   = 2;
    localparam int unsigned CNT_W   = 2;
    localparam int unsigned RETRY_W = 4;
    localparam int unsigned LPTR_W  = 2;

    state_t               state_q, state_d;
    lane_group_t          mem [DEPTH];
    logic                 wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]     count_q;
    logic [LPTR_W-1:0]    lane_ptr_q;
    logic [RETRY_W-1:0]   retry_q, retry_d, retry_inc;

    lane_group_t          in_group;
    lane_sym_t            head_sym;
    logic [LANES-1:0]     com_hit, skp_hit;
    logic                 is_com, is_partial, is_skp, drop_skp;
    logic                 in_fire, out_fire, advance, pop, push, flush;

    // Incoming group and per-lane symbol classification
    always_comb begin
        in_group[0] = {DK_0, LANE0};
        in_group[1] = {DK_1, LANE1};
        in_group[2] = {DK_2, LANE2};
        in_group[3] = {DK_3, LANE3};
        for (int i = 0; i < int'(LANES); i++) begin
            com_hit[i] = in_group[i].dk && (in_group[i].data == COM_SYM);
            skp_hit[i] = in_group[i].dk && (in_group[i].data == SKP_SYM);
        end
    end

    assign is_com     = &com_hit;
    assign is_partial = (|com_hit) && !(&com_hit);
    assign is_skp     = &skp_hit;

`ifdef SKP_DROP_EN
    assign drop_skp = is_skp;
`else
    logic unused_skp;
    assign unused_skp = is_skp;
    assign drop_skp   = 1'b0;
`endif

    assign IN_READY  = (state_q == ST_ERR) || (count_q < CNT_W'(DEPTH));
    assign OUT_VALID = (count_q != '0) && (state_q != ST_ERR);
    assign ALIGNED   = (state_q == ST_RUN);
    assign ALIGN_ERR = (state_q == ST_ERR);

    assign head_sym  = mem[rd_ptr_q][lane_ptr_q];
    assign D         = OUT_VALID ? head_sym.data : 8'h00;
    assign DK        = OUT_VALID && head_sym.dk;

    assign in_fire   = IN_VALID && IN_READY;
    assign out_fire  = OUT_VALID && OUT_READY;
    assign retry_inc = retry_q + RETRY_W'(1);

    // Handshakes are ignored on a flush cycle; that group and byte are lost
    assign advance   = out_fire && !flush;
    assign pop       = advance && (lane_ptr_q == LPTR_W'(LANES - 1));

    always_ff @(posedge CLK or negedge RESET_L) begin
        if (!RESET_L) begin
            state_q <= ST_ALIGN;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        retry_d = retry_q;
        push    = 1'b0;
        flush   = 1'b0;
        if (RESYNC) begin
            flush   = 1'b1;
            retry_d = '0;
            state_d = ST_ALIGN;
        end else begin
            case (state_q)
                ST_ALIGN: begin
                    if (in_fire && is_com) begin
                        push    = 1'b1;
                        state_d = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (in_fire) begin
                        if (is_partial) begin
                            flush   = 1'b1;
                            retry_d = retry_inc;
                            state_d = (retry_inc >= RETRY_W'(MAX_RETRY)) ? ST_ERR : ST_ALIGN;
                        end else if (!drop_skp) begin
                            push = 1'b1;
                        end
                    end
                end
                ST_ERR: begin
                    flush = 1'b0;
                end
                default: begin
                    state_d = ST_ALIGN;
                end
            endcase
        end
    end

    // Two-entry group FIFO, lane pointer and retry counter
    always_ff @(posedge CLK or negedge RESET_L) begin
        if (!RESET_L) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            count_q    <= '0;
            lane_ptr_q <= '0;
            retry_q    <= '0;
        end else begin
            retry_q <= retry_d;
            if (flush) begin
                wr_ptr_q   <= 1'b0;
                rd_ptr_q   <= 1'b0;
                count_q    <= '0;
                lane_ptr_q <= '0;
            end else begin
                if (push) begin
                    mem[wr_ptr_q] <= in_group;
                    wr_ptr_q      <= ~wr_ptr_q;
                end
                if (pop) begin
                    rd_ptr_q <= ~rd_ptr_q;
                end
                if (advance) begin
                    lane_ptr_q <= lane_ptr_q + LPTR_W'(1);
                end
                count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
            end
        end
    end

endmodule
